// File: rtl/reaction_timer_core.sv
// Reaction-game timing datapath: random down-count for the FSM and ms reaction measurement with best-time tracking.
// Outputs are registered, so they update one clk after an enable edge is sampled; there is no backpressure (level enables only).
module reaction_timer_core #(
  parameter int TICK_DIV = 50000,
  parameter int CD_MIN   = 1000,
  parameter int RND_BITS = 11,
  parameter int RT_MAX   = 9999
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        en_dc,
  input  logic        en_c,
  output logic [11:0] countdown,
  output logic [13:0] reaction,
  output logic        rt_valid,
  output logic        overflow,
  output logic [13:0] best
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]   CD_MIN_W  = 12'(CD_MIN);
  localparam logic [13:0]   RT_MAX_W  = 14'(RT_MAX);

  // The largest possible load must stay below 0xFFF, which is reserved as the idle value.
  if (CD_MIN + (1 << RND_BITS) - 1 > 4094) begin : g_bad_cd_range
    $error("reaction_timer_core: CD_MIN + 2**RND_BITS - 1 exceeds 4094");
  end

  typedef enum logic [1:0] {R_IDLE, R_COUNT, R_DONE} r_state_t;

  logic            en_dc_q, en_c_q;
  logic            rise_dc, rise_c, fall_c;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [15:0]     lfsr;
  logic            lfsr_fb;
  logic [11:0]     cd_load;

  r_state_t        state, state_d;
  logic [13:0]     cnt, cnt_d;
  logic [13:0]     reaction_d, best_d;
  logic            rt_valid_d, overflow_d;

  assign rise_dc = en_dc & ~en_dc_q;
  assign rise_c  = en_c & ~en_c_q;
  assign fall_c  = ~en_c & en_c_q;
  assign tick    = (presc == TICK_LAST) && !(rise_dc || rise_c);
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign cd_load = CD_MIN_W + {{(12-RND_BITS){1'b0}}, lfsr[RND_BITS-1:0]};

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      en_dc_q   <= 1'b0;
      en_c_q    <= 1'b0;
      presc     <= '0;
      lfsr      <= 16'hACE1;
      countdown <= 12'hFFF;
    end else begin
      en_dc_q <= en_dc;
      en_c_q  <= en_c;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      // A start of either measurement realigns the ms grid to that start.
      if (rise_dc || rise_c || presc == TICK_LAST)
        presc <= '0;
      else
        presc <= presc + PW'(1);
      if (!en_dc)
        countdown <= 12'hFFF;
      else if (rise_dc)
        countdown <= cd_load;
      else if (tick && countdown != 12'd0)
        countdown <= countdown - 12'd1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= R_IDLE;
      cnt      <= '0;
      reaction <= '0;
      rt_valid <= 1'b0;
      overflow <= 1'b0;
      best     <= RT_MAX_W;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      reaction <= reaction_d;
      rt_valid <= rt_valid_d;
      overflow <= overflow_d;
      best     <= best_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    reaction_d = reaction;
    rt_valid_d = 1'b0;
    overflow_d = overflow;
    best_d     = best;
    case (state)
      R_IDLE, R_DONE: begin
        if (rise_c) begin
          state_d    = R_COUNT;
          cnt_d      = '0;
          overflow_d = 1'b0;
        end
      end
      R_COUNT: begin
        if (tick) begin
          if (cnt < RT_MAX_W) cnt_d = cnt + 14'd1;
          else                overflow_d = 1'b1;
        end
        // The latch includes a tick landing in the release cycle.
        if (fall_c) begin
          state_d    = R_DONE;
          reaction_d = cnt_d;
          rt_valid_d = 1'b1;
          if (!overflow_d && cnt_d < best) best_d = cnt_d;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Randomized bench for reaction_timer_core against a cycle-count reference model (TICK_DIV=4, CD_MIN=10, RND_BITS=3).
module tb_reaction_timer_core;

  logic        clk = 1'b0;
  logic        Reset;
  logic        en_dc, en_c;
  logic [11:0] countdown;
  logic [13:0] reaction;
  logic        rt_valid;
  logic        overflow;
  logic [13:0] best;

  int checks   = 0;
  int failures = 0;
  int best_m   = 9999;
  logic [15:0] lfsr_m;

  reaction_timer_core #(
    .TICK_DIV(4), .CD_MIN(10), .RND_BITS(3), .RT_MAX(9999)
  ) dut (
    .clk(clk), .Reset(Reset), .en_dc(en_dc), .en_c(en_c),
    .countdown(countdown), .reaction(reaction), .rt_valid(rt_valid),
    .overflow(overflow), .best(best)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, one step per clk.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v, b;
    v = int'(s);
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  always @(posedge clk or posedge Reset)
    if (Reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_step(lfsr_m);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_countdown"}, countdown, 12'hFFF);
    check({tag, "_reaction"}, reaction, 0);
    check({tag, "_rt_valid"}, rt_valid, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_best"}, best, 9999);
  endtask

  // Ticks fall every 4 clks after the rise; countdown = load - elapsed ticks, floored at 0.
  function automatic int cd_expect(input int load, input int m);
    int e;
    e = load - (m - 1) / 4;
    return (e < 0) ? 0 : e;
  endfunction

  task automatic countdown_run(input int hold, input bit drop_at5);
    int load, e;
    load  = 10 + int'(lfsr_m & 16'h7);
    en_dc = 1'b1;
    for (int m = 1; m <= hold; m++) begin
      @(negedge clk);
      e = cd_expect(load, m);
      check("cd_count", countdown, e);
      if (drop_at5 && e == 5) break;
    end
    en_dc = 1'b0;
    @(negedge clk);
    check("cd_idle", countdown, 12'hFFF);
  endtask

  // en_c high for n clks: the measurement is the number of whole ticks, saturating at 9999.
  task automatic react_run(input int n);
    int  e;
    bit  ov, early;
    e     = n / 4;
    ov    = (e > 9999);
    if (ov) e = 9999;
    early = 1'b0;
    en_c  = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (rt_valid) early = 1'b1;
    end
    check("rt_valid_quiet", early, 0);
    if (ov) check("overflow_live", overflow, 1);
    en_c = 1'b0;
    @(negedge clk);
    check("rt_valid_pulse", rt_valid, 1);
    check("reaction", reaction, e);
    check("overflow", overflow, ov);
    if (!ov && e < best_m) best_m = e;
    check("best", best, best_m);
    @(negedge clk);
    check("rt_valid_end", rt_valid, 0);
  endtask

  initial begin
    Reset = 1'b1;
    en_dc = 1'b0;
    en_c  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("after_reset");

    countdown_run(200, 1'b0);
    countdown_run(200, 1'b1);
    countdown_run(200, 1'b0);
    repeat (4) begin
      repeat ($urandom_range(1, 7)) @(negedge clk);
      countdown_run($urandom_range(20, 90), 1'($urandom_range(0, 1)));
    end

    react_run(4 * 37);
    react_run(4 * 50);
    react_run(4 * 20);
    repeat (8) begin
      repeat ($urandom_range(1, 9)) @(negedge clk);
      react_run($urandom_range(30, 400));
    end

    // Both channels started together share one prescaler clear.
    begin
      int load, n;
      n     = $urandom_range(60, 120);
      load  = 10 + int'(lfsr_m & 16'h7);
      en_dc = 1'b1;
      en_c  = 1'b1;
      for (int m = 1; m <= n; m++) begin
        @(negedge clk);
        check("dual_cd", countdown, cd_expect(load, m));
      end
      en_c = 1'b0;
      @(negedge clk);
      check("dual_rt_valid", rt_valid, 1);
      check("dual_reaction", reaction, n / 4);
      if (n / 4 < best_m) best_m = n / 4;
      check("dual_best", best, best_m);
      en_dc = 1'b0;
      @(negedge clk);
      check("dual_cd_idle", countdown, 12'hFFF);
    end

    react_run(4 * 10000 + 8);

    // New run clears overflow; reset mid-count restores everything before the next edge.
    en_dc = 1'b1;
    en_c  = 1'b1;
    repeat (60) @(negedge clk);
    check("ovf_cleared", overflow, 0);
    check("reaction_held", reaction, 9999);
    #2 Reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    best_m = 9999;
    @(negedge clk);
    en_dc = 1'b0;
    en_c  = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    react_run(4 * 15 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
